// File: rtl/mem_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_burst_reader
// Description : Sequential burst reader for a 1-cycle-latency memory, with a
//               2-entry skid buffer feeding a valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_burst_reader #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_addr;
  logic [AW:0]   r_len;
  logic [AW:0]   r_issue_left;
  logic [AW:0]   r_beat_cnt;
  logic          r_inflight;

  logic [DW-1:0] r_buf_data [2];
  logic [1:0]    r_buf_last;
  logic          r_wptr;
  logic          r_rptr;
  logic [1:0]    r_count;

  logic          w_pop;
  logic          w_issue;
  logic          w_cap_last;
  logic [1:0]    w_pending;

  assign w_pop      = out_valid & out_ready;
  // A beat leaving this cycle frees a slot, keeping one beat per cycle under full throughput
  assign w_pending  = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_cap_last = ((r_beat_cnt + {{AW{1'b0}}, 1'b1}) == r_len);
  assign w_issue    = mem_rd_en;

  assign mem_rd_addr = r_addr;
  assign out_valid   = (r_count != 2'd0);
  assign out_data    = r_buf_data[r_rptr];
  assign out_last    = out_valid & r_buf_last[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    mem_rd_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = (length == '0) ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        mem_rd_en = (w_pending < 2'd2);
        if (mem_rd_en && (r_issue_left == {{AW{1'b0}}, 1'b1})) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && out_last) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr        <= '0;
      r_len         <= '0;
      r_issue_left  <= '0;
      r_beat_cnt    <= '0;
      r_inflight    <= 1'b0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_last    <= '0;
      r_wptr        <= 1'b0;
      r_rptr        <= 1'b0;
      r_count       <= '0;
    end else begin
      r_inflight <= w_issue;

      if ((r_state == S_IDLE) && start) begin
        r_addr       <= start_addr;
        r_len        <= length;
        r_issue_left <= length;
        r_beat_cnt   <= '0;
      end else if (w_issue) begin
        r_addr       <= r_addr + 1'b1;
        r_issue_left <= r_issue_left - 1'b1;
      end

      // Read data returns one cycle after issue; the issue rule guarantees a free slot
      if (r_inflight) begin
        r_buf_data[r_wptr] <= mem_rd_data;
        r_buf_last[r_wptr] <= w_cap_last;
        r_wptr             <= ~r_wptr;
        r_beat_cnt         <= r_beat_cnt + 1'b1;
      end

      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end

      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
`default_nettype none
// Scoreboard bench for mem_burst_reader: a bench-side memory model feeds reads,
// expected beats are queued at start and compared as the DUT hands them off.
module tb_mem_burst_reader;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, mem_rd_en, out_valid, out_last;
  logic          out_ready = 1'b1;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] out_data;

  mem_burst_reader #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [32];
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats_seen = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int issued = 0;
  int popped = 0;
  int last_hs_cyc = -1;
  int start_cyc = 0;

  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [AW-1:0] addr_log [$];

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  logic [DW-1:0] ed;
  logic          el;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++;
          $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (mem_rd_en) begin
        issued++;
        addr_log.push_back(mem_rd_addr);
      end
      if (out_valid && out_ready) begin
        popped++;
        beats_seen++;
        checks++;
        if (exp_data.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: data=%h last=%b, required no beat", out_data, out_last);
        end else begin
          ed = exp_data.pop_front();
          el = exp_last.pop_front();
          if (out_data !== ed || out_last !== el) begin
            errors++;
            $display("FAIL beat: data=%h last=%b, required data=%h last=%b",
                     out_data, out_last, ed, el);
          end
          if (el) last_hs_cyc = cyc;
        end
      end
      checks++;
      if (issued - popped > 2) begin
        errors++;
        $display("FAIL outstanding: %0d, required <= 2", issued - popped);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input int l);
    for (int i = 0; i < l; i++) begin
      logic [AW-1:0] ad;
      ad = a + AW'(i);
      exp_data.push_back(mem[ad]);
      exp_last.push_back(i == l - 1);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] a, input logic [AW:0] l);
    @(posedge clk); #1;
    start_addr = a;
    length     = l;
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string name);
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk); #2;
      if (done_cnt > base) break;
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen, required done pulse", name);
    end
  endtask

  task automatic check_end(input int base, input string name);
    checks++;
    if (done_cyc !== last_hs_cyc + 1) begin
      errors++;
      $display("FAIL %s_done_timing: done cycle %0d, required %0d", name, done_cyc, last_hs_cyc + 1);
    end
    checks++;
    if (exp_data.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d beats left, required 0", name, exp_data.size());
    end
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (done_cnt != base + 1) begin
      errors++;
      $display("FAIL %s_done_count: %0d, required %0d", name, done_cnt - base, 1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0 || mem_rd_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b en=%b valid=%b last=%b addr=%h data=%h, required all 0",
               busy, done, mem_rd_en, out_valid, out_last, mem_rd_addr, out_data);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int base;
    base = done_cnt;
    mem[10] = 32'd20;
    mem[11] = 32'd22;
    out_ready = 1'b1;
    push_exp(5'd10, 2);
    pulse_start(5'd10, 6'd2);
    wait_done(base, "basic");
    check_end(base, "basic");
  endtask

  task automatic test_wrap;
    int base;
    base = done_cnt;
    mem[30] = 32'd30;
    mem[31] = 32'd31;
    mem[0]  = 32'd100;
    mem[1]  = 32'd101;
    addr_log.delete();
    push_exp(5'd30, 4);
    pulse_start(5'd30, 6'd4);
    wait_done(base, "wrap");
    check_end(base, "wrap");
    checks++;
    if (addr_log.size() != 4) begin
      errors++;
      $display("FAIL wrap_issue_count: %0d, required 4", addr_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [AW-1:0] ea;
        ea = 5'd30 + AW'(i);
        checks++;
        if (addr_log[i] !== ea) begin
          errors++;
          $display("FAIL wrap_addr[%0d]: %0d, required %0d", i, addr_log[i], ea);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int base;
    int k;
    base = done_cnt;
    issued = 0;
    popped = 0;
    beats_seen = 0;
    out_ready = 1'b1;
    push_exp(5'd4, 6);
    pulse_start(5'd4, 6'd6);
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (beats_seen >= 1) break;
    end
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (beats_seen != 1 || issued != 3) begin
      errors++;
      $display("FAIL bp_stall: beats=%0d issued=%0d, required beats=1 issued=3", beats_seen, issued);
    end
    out_ready = 1'b1;
    wait_done(base, "bp");
    check_end(base, "bp");
    checks++;
    if (beats_seen != 6) begin
      errors++;
      $display("FAIL bp_beats: %0d, required 6", beats_seen);
    end
  endtask

  task automatic test_zero_len;
    int base;
    base = done_cnt;
    issued = 0;
    beats_seen = 0;
    pulse_start(5'd7, 6'd0);
    wait_done(base, "zero");
    checks++;
    if (done_cyc !== start_cyc + 1 || issued != 0 || beats_seen != 0) begin
      errors++;
      $display("FAIL zero_len: done_cyc=%0d issued=%0d beats=%0d, required done_cyc=%0d issued=0 beats=0",
               done_cyc, issued, beats_seen, start_cyc + 1);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int k;
    beats_seen = 0;
    issued = 0;
    popped = 0;
    out_ready = 1'b1;
    push_exp(5'd8, 8);
    pulse_start(5'd8, 6'd8);
    for (k = 0; k < 50; k++) begin
      @(posedge clk); #2;
      if (beats_seen >= 3) break;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0 || mem_rd_addr !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b en=%b valid=%b last=%b addr=%h data=%h, required all 0",
               busy, done, mem_rd_en, out_valid, out_last, mem_rd_addr, out_data);
    end
    exp_data.delete();
    exp_last.delete();
    issued = 0;
    popped = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    base = done_cnt;
    addr_log.delete();
    push_exp(5'd0, 2);
    pulse_start(5'd0, 6'd2);
    wait_done(base, "post_reset");
    check_end(base, "post_reset");
    checks++;
    if (addr_log.size() != 2 || addr_log[0] !== 5'd0 || addr_log[1] !== 5'd1) begin
      errors++;
      $display("FAIL post_reset_addr: %0d issues, required 2 issues at 0,1", addr_log.size());
    end
  endtask

  task automatic test_start_busy;
    int base;
    base = done_cnt;
    beats_seen = 0;
    out_ready = 1'b1;
    push_exp(5'd12, 4);
    pulse_start(5'd12, 6'd4);
    @(posedge clk); #1;
    start_addr = 5'd20;
    length     = 6'd3;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(base, "busy_start");
    check_end(base, "busy_start");
    checks++;
    if (beats_seen != 4) begin
      errors++;
      $display("FAIL busy_start_beats: %0d, required 4", beats_seen);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 + i;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
